// File: rtl/periph_responder_pkg.sv
// Shared constants for the peripheral responder: register offsets, TCTRL bit
// positions and UART transmitter state encodings.
package periph_responder_pkg;

   localparam logic [4:0] PERIPH_LED    = 5'h00;
   localparam logic [4:0] PERIPH_SW     = 5'h04;
   localparam logic [4:0] PERIPH_TLOAD  = 5'h08;
   localparam logic [4:0] PERIPH_TCTRL  = 5'h0C;
   localparam logic [4:0] PERIPH_TCOUNT = 5'h10;
   localparam logic [4:0] PERIPH_UTXD   = 5'h14;
   localparam logic [4:0] PERIPH_USTAT  = 5'h18;

   localparam int TCTRL_EN   = 0;
   localparam int TCTRL_IE   = 1;
   localparam int TCTRL_PEND = 2;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/periph_responder_uart_tx.sv
// 8N1 UART transmitter with a small TX FIFO; each bit lasts CLK_DIV cycles.
//  state      | meaning
//  UART_IDLE  | line high, waiting for the FIFO to hold a byte
//  UART_START | start bit (0)
//  UART_DATA  | eight data bits, LSB first
//  UART_STOP  | stop bit (1); pops the next byte straight into START if queued
module uart_tx
   import periph_responder_pkg::*;
#(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 4,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [7:0]    data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          busy,
   output logic          tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_TOP = BW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic          pop, push_ok;

   uart_state_e   state, state_nxt;
   logic [BW-1:0] baud, baud_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shreg, shreg_nxt;

   assign empty   = (cnt == '0);
   assign full    = (cnt == DEPTH_C);
   assign count   = cnt;
   assign busy    = (state != UART_IDLE);
   // a pop in the same cycle frees the slot, so a push into a full FIFO is fine then
   assign push_ok = push & (~full | pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= UART_IDLE;
         baud    <= BAUD_TOP;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nxt;
         baud    <= baud_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      baud_nxt    = baud;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      pop         = 1'b0;
      case (state)
         UART_IDLE: begin
            baud_nxt = BAUD_TOP;
            if (!empty) begin
               pop       = 1'b1;
               shreg_nxt = mem[rd_ptr];
               state_nxt = UART_START;
            end
         end
         UART_START: begin
            if (baud == '0) begin
               baud_nxt    = BAUD_TOP;
               bit_idx_nxt = '0;
               state_nxt   = UART_DATA;
            end else begin
               baud_nxt = baud - 1'b1;
            end
         end
         UART_DATA: begin
            if (baud == '0) begin
               baud_nxt  = BAUD_TOP;
               shreg_nxt = {1'b0, shreg[7:1]};
               if (bit_idx == 3'd7) state_nxt = UART_STOP;
               else                 bit_idx_nxt = bit_idx + 1'b1;
            end else begin
               baud_nxt = baud - 1'b1;
            end
         end
         UART_STOP: begin
            if (baud == '0) begin
               baud_nxt = BAUD_TOP;
               if (!empty) begin
                  pop       = 1'b1;
                  shreg_nxt = mem[rd_ptr];
                  state_nxt = UART_START;
               end else begin
                  state_nxt = UART_IDLE;
               end
            end else begin
               baud_nxt = baud - 1'b1;
            end
         end
         default: state_nxt = UART_IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (state)
         UART_START: tx = 1'b0;
         UART_DATA:  tx = shreg[0];
         default:    tx = 1'b1;
      endcase
   end

endmodule

// File: rtl/periph_responder.sv
// Memory-mapped peripheral responder: LEDs, switches, reloading timer with IRQ,
// and a UART transmitter built only when PERIPH_UART_EN is defined.
module periph_responder
   import periph_responder_pkg::*;
#(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic        we_i,
   output logic [31:0] data_o,
   input  logic [15:0] sw_i,
   output logic [15:0] led_o,
   output logic        irq_o,
   output logic        uart_tx_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [4:0]  reg_off;
   logic [15:0] sw_meta, sw_sync, led_q;
   logic [31:0] tload, tcount, ustat;
   logic        t_en, t_ie, t_pend;
   logic        wr_led, wr_tload, wr_tctrl;
   logic        unused_addr;

   // only the word index is decoded; byte lanes and upper bits alias
   assign reg_off     = {addr_i[4:2], 2'b00};
   assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};
   assign wr_led      = we_i && (reg_off == PERIPH_LED);
   assign wr_tload    = we_i && (reg_off == PERIPH_TLOAD);
   assign wr_tctrl    = we_i && (reg_off == PERIPH_TCTRL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta <= '0;
         sw_sync <= '0;
         led_q   <= '0;
      end else begin
         sw_meta <= sw_i;
         sw_sync <= sw_meta;
         if (wr_led) led_q <= data_i[15:0];
      end
   end

   // terminal count sets PEND ahead of a simultaneous W1C; a TLOAD write beats the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tload  <= '0;
         tcount <= '0;
         t_en   <= 1'b0;
         t_ie   <= 1'b0;
         t_pend <= 1'b0;
      end else begin
         if (wr_tload) tload <= data_i;
         if (wr_tload)                  tcount <= data_i;
         else if (t_en && tcount == '0) tcount <= tload;
         else if (t_en)                 tcount <= tcount - 32'd1;
         if (wr_tctrl) begin
            t_en <= data_i[TCTRL_EN];
            t_ie <= data_i[TCTRL_IE];
         end
         if (t_en && tcount == '0)                t_pend <= 1'b1;
         else if (wr_tctrl && data_i[TCTRL_PEND]) t_pend <= 1'b0;
      end
   end

   assign led_o = led_q;
   assign irq_o = t_pend & t_ie;

`ifdef PERIPH_UART_EN
   logic          u_full, u_empty, u_busy;
   logic [CW-1:0] u_count;

   uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_uart_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (we_i && (reg_off == PERIPH_UTXD)),
      .data  (data_i[7:0]),
      .full  (u_full),
      .empty (u_empty),
      .count (u_count),
      .busy  (u_busy),
      .tx    (uart_tx_o)
   );

   assign ustat = {24'h0, 4'(u_count), 1'b0, u_empty, u_full, u_busy};
`else
   assign uart_tx_o = 1'b1;
   assign ustat     = 32'h0;
`endif

   always_comb begin
      data_o = 32'h0;
      case (reg_off)
         PERIPH_LED:    data_o = {16'h0, led_q};
         PERIPH_SW:     data_o = {16'h0, sw_sync};
         PERIPH_TLOAD:  data_o = tload;
         PERIPH_TCTRL:  data_o = {29'h0, t_pend, t_ie, t_en};
         PERIPH_TCOUNT: data_o = tcount;
         PERIPH_USTAT:  data_o = ustat;
         default:       data_o = 32'h0;
      endcase
   end

endmodule
